// File: rtl/axi_rt_lite_cfg_seq_if.sv
// AXI4-Lite write-only channel bundle between the configuration sequencer
// and the RT unit's configuration port.
interface axi_rt_lite_cfg_seq_if #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32
);
   logic [AddrWidth-1:0]   awaddr;
   logic [2:0]             awprot;
   logic                   awvalid;
   logic                   awready;
   logic [DataWidth-1:0]   wdata;
   logic [DataWidth/8-1:0] wstrb;
   logic                   wvalid;
   logic                   wready;
   logic [1:0]             bresp;
   logic                   bvalid;
   logic                   bready;

   modport master (
      output awaddr, awprot, awvalid,
      input  awready,
      output wdata, wstrb, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready
   );

   modport slave (
      input  awaddr, awprot, awvalid,
      output awready,
      input  wdata, wstrb, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/axi_rt_lite_cfg_seq.sv
// Walks a configuration table and issues one AXI4-Lite write per entry,
// retrying error responses a bounded number of times before aborting.
module axi_rt_lite_cfg_seq #(
   parameter int unsigned AddrWidth  = 32,
   parameter int unsigned DataWidth  = 32,
   parameter int unsigned IdxWidth   = 6,
   parameter int unsigned MaxRetries = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [IdxWidth-1:0]  num_entries_i,
   output logic [IdxWidth-1:0]  tbl_idx_o,
   input  logic [AddrWidth-1:0] tbl_addr_i,
   input  logic [DataWidth-1:0] tbl_data_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 error_o,
   output logic [IdxWidth-1:0]  err_idx_o,
   axi_rt_lite_cfg_seq_if.master m_axi_lite
);
   localparam int unsigned RetryWidth = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_RESP, S_DONE} state_t;

   state_t                r_state, w_state_nxt;
   logic [IdxWidth-1:0]   r_num, w_num_nxt;
   logic [IdxWidth-1:0]   r_idx, w_idx_nxt;
   logic [IdxWidth-1:0]   r_err_idx, w_err_idx_nxt;
   logic [RetryWidth-1:0] r_retry, w_retry_nxt;
   logic [AddrWidth-1:0]  r_awaddr, w_awaddr_nxt;
   logic [DataWidth-1:0]  r_wdata, w_wdata_nxt;
   logic                  r_awvalid, w_awvalid_nxt;
   logic                  r_wvalid, w_wvalid_nxt;
   logic                  r_error, w_error_nxt;
   logic [IdxWidth-1:0]   w_idx_inc;
   logic                  w_aw_ok, w_w_ok, w_bresp_err;

   assign w_idx_inc   = r_idx + IdxWidth'(1);
   // A channel is finished once its valid is gone or its handshake happens now.
   assign w_aw_ok     = !r_awvalid || m_axi_lite.awready;
   assign w_w_ok      = !r_wvalid  || m_axi_lite.wready;
   assign w_bresp_err = (m_axi_lite.bresp == 2'b10) || (m_axi_lite.bresp == 2'b11);

   always_comb begin
      w_state_nxt   = r_state;
      w_num_nxt     = r_num;
      w_idx_nxt     = r_idx;
      w_err_idx_nxt = r_err_idx;
      w_retry_nxt   = r_retry;
      w_awaddr_nxt  = r_awaddr;
      w_wdata_nxt   = r_wdata;
      w_awvalid_nxt = r_awvalid;
      w_wvalid_nxt  = r_wvalid;
      w_error_nxt   = r_error;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               if (num_entries_i != '0) begin
                  w_num_nxt     = num_entries_i;
                  w_idx_nxt     = '0;
                  w_retry_nxt   = '0;
                  w_error_nxt   = 1'b0;
                  w_err_idx_nxt = '0;
                  w_state_nxt   = S_LOAD;
               end else begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_LOAD: begin
            w_awaddr_nxt  = tbl_addr_i;
            w_wdata_nxt   = tbl_data_i;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_state_nxt   = S_ISSUE;
         end
         S_ISSUE: begin
            if (r_awvalid && m_axi_lite.awready) w_awvalid_nxt = 1'b0;
            if (r_wvalid && m_axi_lite.wready)   w_wvalid_nxt  = 1'b0;
            if (w_aw_ok && w_w_ok)               w_state_nxt   = S_RESP;
         end
         S_RESP: begin
            if (m_axi_lite.bvalid) begin
               if (!w_bresp_err) begin
                  w_retry_nxt = '0;
                  w_idx_nxt   = w_idx_inc;
                  w_state_nxt = (w_idx_inc == r_num) ? S_DONE : S_LOAD;
               end else if (r_retry < RetryWidth'(MaxRetries)) begin
                  w_retry_nxt   = r_retry + RetryWidth'(1);
                  w_awvalid_nxt = 1'b1;
                  w_wvalid_nxt  = 1'b1;
                  w_state_nxt   = S_ISSUE;
               end else begin
                  w_retry_nxt   = '0;
                  w_error_nxt   = 1'b1;
                  w_err_idx_nxt = r_idx;
                  w_state_nxt   = S_DONE;
               end
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_num     <= '0;
         r_idx     <= '0;
         r_err_idx <= '0;
         r_retry   <= '0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_num     <= w_num_nxt;
         r_idx     <= w_idx_nxt;
         r_err_idx <= w_err_idx_nxt;
         r_retry   <= w_retry_nxt;
         r_awaddr  <= w_awaddr_nxt;
         r_wdata   <= w_wdata_nxt;
         r_awvalid <= w_awvalid_nxt;
         r_wvalid  <= w_wvalid_nxt;
         r_error   <= w_error_nxt;
      end
   end

   assign tbl_idx_o = r_idx;
   assign busy_o    = (r_state != S_IDLE);
   assign done_o    = (r_state == S_DONE);
   assign error_o   = r_error;
   assign err_idx_o = r_err_idx;

   assign m_axi_lite.awaddr  = r_awaddr;
   assign m_axi_lite.awprot  = 3'b000;
   assign m_axi_lite.awvalid = r_awvalid;
   assign m_axi_lite.wdata   = r_wdata;
   assign m_axi_lite.wstrb   = '1;
   assign m_axi_lite.wvalid  = r_wvalid;
   assign m_axi_lite.bready  = (r_state == S_RESP);
endmodule

// File: tb/tb_axi_rt_lite_cfg_seq.sv
// Directed bench for axi_rt_lite_cfg_seq: a scoreboard of expected AW/W beats,
// a scripted B responder, and handshake/latency/hold monitoring.
module tb_axi_rt_lite_cfg_seq;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned IW = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [IW-1:0] num = '0;
   logic [IW-1:0] tbl_idx;
   logic [AW-1:0] tbl_addr;
   logic [DW-1:0] tbl_data;
   logic          busy, done, error;
   logic [IW-1:0] err_idx;

   logic          s_awready = 1'b1;
   logic          s_wready  = 1'b1;
   logic          s_bvalid  = 1'b0;
   logic [1:0]    s_bresp   = 2'b00;

   logic [AW-1:0] tbl_a [64];
   logic [DW-1:0] tbl_d [64];

   logic [AW-1:0] exp_aw [$];
   logic [DW-1:0] exp_w  [$];
   logic [1:0]    resp_q [$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc = 0, ref_cyc = 0, done_cnt = 0, av_rises = 0;
   logic lat_en = 1'b0;
   logic aw_hs_f = 1'b0, w_hs_f = 1'b0, b_hs_f = 1'b0;
   logic aw_got = 1'b0, w_got = 1'b0;
   logic prev_awv = 1'b0, prev_aw_hs = 1'b0;
   logic [AW-1:0] prev_awaddr = '0;

   axi_rt_lite_cfg_seq_if #(.AddrWidth(AW), .DataWidth(DW)) axi ();

   assign axi.awready = s_awready;
   assign axi.wready  = s_wready;
   assign axi.bvalid  = s_bvalid;
   assign axi.bresp   = s_bresp;
   assign tbl_addr    = tbl_a[tbl_idx];
   assign tbl_data    = tbl_d[tbl_idx];

   axi_rt_lite_cfg_seq #(
      .AddrWidth(AW), .DataWidth(DW), .IdxWidth(IW), .MaxRetries(2)
   ) u_dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .num_entries_i(num),
      .tbl_idx_o(tbl_idx), .tbl_addr_i(tbl_addr), .tbl_data_i(tbl_data),
      .busy_o(busy), .done_o(done), .error_o(error), .err_idx_o(err_idx),
      .m_axi_lite(axi)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: samples mid-cycle; a valid&ready seen here completes at the next rising edge.
   always @(negedge clk) begin
      if (rst) begin
         prev_awv   = 1'b0;
         prev_aw_hs = 1'b0;
      end else begin
         cyc++;
         if (start && !busy) ref_cyc = cyc;
         if (axi.bvalid && axi.bready) begin
            ref_cyc = cyc;
            b_hs_f  = 1'b1;
         end
         if (axi.awvalid && !prev_awv) begin
            av_rises++;
            if (lat_en) check("aw_latency", 64'(cyc - ref_cyc), 64'd2);
         end
         if (prev_awv && !prev_aw_hs)
            check("aw_hold", {31'd0, axi.awvalid, axi.awaddr}, {31'd0, 1'b1, prev_awaddr});
         if (axi.awvalid && axi.awready) begin
            aw_hs_f = 1'b1;
            if (exp_aw.size() == 0) check("aw_extra", 64'(axi.awaddr), 64'hDEAD);
            else check("awaddr", 64'(axi.awaddr), 64'(exp_aw.pop_front()));
            check("awprot", 64'(axi.awprot), 64'd0);
         end
         if (axi.wvalid && axi.wready) begin
            w_hs_f = 1'b1;
            if (exp_w.size() == 0) check("w_extra", 64'(axi.wdata), 64'hDEAD);
            else check("wdata", 64'(axi.wdata), 64'(exp_w.pop_front()));
            check("wstrb", 64'(axi.wstrb), 64'hF);
         end
         if (done) done_cnt++;
         prev_awv    = axi.awvalid;
         prev_aw_hs  = axi.awvalid && axi.awready;
         prev_awaddr = axi.awaddr;
      end
   end

   // B responder: answers once both AW and W of a write have been accepted.
   always @(posedge clk) begin
      #1;
      if (rst) begin
         s_bvalid = 1'b0;
         aw_got   = 1'b0;
         w_got    = 1'b0;
      end else begin
         if (b_hs_f) s_bvalid = 1'b0;
         if (aw_hs_f) aw_got = 1'b1;
         if (w_hs_f)  w_got  = 1'b1;
         if (aw_got && w_got && !s_bvalid) begin
            s_bresp  = (resp_q.size() != 0) ? resp_q.pop_front() : 2'b00;
            s_bvalid = 1'b1;
            aw_got   = 1'b0;
            w_got    = 1'b0;
         end
      end
      aw_hs_f = 1'b0;
      w_hs_f  = 1'b0;
      b_hs_f  = 1'b0;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_entry(input int i);
      exp_aw.push_back(tbl_a[i]);
      exp_w.push_back(tbl_d[i]);
   endtask

   task automatic start_pulse(input logic [IW-1:0] n);
      done_cnt = 0;
      @(posedge clk); #1;
      num   = n;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 300; k++) begin
         if (done_cnt > 0) break;
         @(posedge clk); #1;
      end
      check("done_seen", 64'(done_cnt > 0), 64'd1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("done_pulses", 64'(done_cnt), 64'd1);
      check("busy_after", 64'(busy), 64'd0);
      check("exp_aw_empty", 64'(exp_aw.size()), 64'd0);
      check("exp_w_empty", 64'(exp_w.size()), 64'd0);
   endtask

   initial begin
      tbl_a[0] = 32'h0; tbl_d[0] = 32'h11;
      tbl_a[1] = 32'h4; tbl_d[1] = 32'h22;
      tbl_a[2] = 32'h8; tbl_d[2] = 32'h33;
      for (int i = 3; i < 64; i++) begin
         tbl_a[i] = 32'hA000_0000 + 32'(i * 4);
         tbl_d[i] = 32'h5500_0000 + 32'(i);
      end

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_awvalid", 64'(axi.awvalid), 64'd0);
      check("rst_wvalid", 64'(axi.wvalid), 64'd0);
      check("rst_bready", 64'(axi.bready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      check("rst_idx", 64'(tbl_idx), 64'd0);
      check("rst_err_idx", 64'(err_idx), 64'd0);
      check("rst_awaddr", 64'(axi.awaddr), 64'd0);
      check("rst_wdata", 64'(axi.wdata), 64'd0);
      rst = 1'b0;

      // Three entries, all channels always ready
      lat_en = 1'b1;
      for (int i = 0; i < 3; i++) push_entry(i);
      start_pulse(IW'(3));
      check("busy_after_start", 64'(busy), 64'd1);
      wait_done();
      check("t1_error", 64'(error), 64'd0);
      check("t1_idx_end", 64'(tbl_idx), 64'd3);

      // AW ready held off: W completes first, AW held stable
      s_awready = 1'b0;
      for (int i = 0; i < 3; i++) push_entry(i);
      start_pulse(IW'(3));
      for (int k = 0; k < 20; k++) begin
         if (axi.awvalid) break;
         @(posedge clk); #1;
      end
      check("t2_awvalid_up", 64'(axi.awvalid), 64'd1);
      @(posedge clk); #1;
      check("t2_wvalid_drop", 64'(axi.wvalid), 64'd0);
      check("t2_awvalid_hold", 64'(axi.awvalid), 64'd1);
      @(posedge clk); #1;
      check("t2_awvalid_hold2", 64'(axi.awvalid), 64'd1);
      check("t2_bready_wait", 64'(axi.bready), 64'd0);
      s_awready = 1'b1;
      wait_done();
      lat_en = 1'b0;

      // Entry 1 fails twice with SLVERR, then succeeds
      push_entry(0); push_entry(1); push_entry(1); push_entry(1); push_entry(2);
      resp_q.push_back(2'b00); resp_q.push_back(2'b10); resp_q.push_back(2'b10);
      resp_q.push_back(2'b00); resp_q.push_back(2'b00);
      start_pulse(IW'(3));
      wait_done();
      check("t3_error", 64'(error), 64'd0);
      check("t3_resp_used", 64'(resp_q.size()), 64'd0);

      // Entry 1 fails three times with DECERR: abort, entry 2 never issued
      push_entry(0); push_entry(1); push_entry(1); push_entry(1);
      resp_q.push_back(2'b00); resp_q.push_back(2'b11);
      resp_q.push_back(2'b11); resp_q.push_back(2'b11);
      start_pulse(IW'(3));
      wait_done();
      check("t4_error", 64'(error), 64'd1);
      check("t4_err_idx", 64'(err_idx), 64'd1);

      // New start clears the error; reset mid-transaction drops everything
      s_awready = 1'b0;
      start_pulse(IW'(3));
      check("t5_error_cleared", 64'(error), 64'd0);
      check("t5_err_idx_cleared", 64'(err_idx), 64'd0);
      for (int k = 0; k < 20; k++) begin
         if (axi.awvalid) break;
         @(posedge clk); #1;
      end
      check("t5_awvalid_up", 64'(axi.awvalid), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check("t5_async_awvalid", 64'(axi.awvalid), 64'd0);
      check("t5_async_wvalid", 64'(axi.wvalid), 64'd0);
      check("t5_async_busy", 64'(busy), 64'd0);
      check("t5_async_error", 64'(error), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      s_awready = 1'b1;
      check("t5_idx_reset", 64'(tbl_idx), 64'd0);
      for (int i = 0; i < 3; i++) push_entry(i);
      start_pulse(IW'(3));
      wait_done();

      // Zero entries: immediate done, no bus traffic
      begin
         int rises_before;
         rises_before = av_rises;
         start_pulse(IW'(0));
         check("t6_done_now", 64'(done), 64'd1);
         @(posedge clk); #1;
         check("t6_done_gone", 64'(done), 64'd0);
         check("t6_busy", 64'(busy), 64'd0);
         repeat (3) @(posedge clk);
         #1;
         check("t6_no_valid", 64'(av_rises - rises_before), 64'd0);
         check("t6_done_pulses", 64'(done_cnt), 64'd1);
      end

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end
endmodule

// File: doc/axi_rt_lite_cfg_seq.md
Name: axi_rt_lite_cfg_seq

Overview:
- AXI4-Lite write-only manager that drives the RT unit's AXI-Lite configuration port after reset or on request.
- Walks a combinational configuration table of (address, data) pairs and issues one AXI-Lite write per entry.
- Checks every B response, retries failed writes a bounded number of times, and reports completion and error status to the system controller.

Parameters:
AddrWidth, 32, AXI-Lite address width; equals the RT unit's config port address width.
DataWidth, 32, AXI-Lite data width; strobe width is DataWidth/8.
IdxWidth, 6, table index width; at most 2^IdxWidth-1 entries.
MaxRetries, 2, extra attempts per entry after SLVERR/DECERR; 0 disables retry.

Ports:
clk_i  in  1  clock; only clock of the block
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  start a sequence (level sampled at clock edge)
num_entries_i  in  IdxWidth  number of table entries to write
tbl_idx_o  out  IdxWidth  current table index
tbl_addr_i  in  AddrWidth  table address at tbl_idx_o (combinational lookup)
tbl_data_i  in  DataWidth  table data at tbl_idx_o
busy_o  out  1  sequence in progress
done_o  out  1  one-cycle pulse at sequence end
error_o  out  1  sticky: last sequence aborted on an error response
err_idx_o  out  IdxWidth  index of the failing entry, valid while error_o=1
m_axi_lite_awaddr_o  out  AddrWidth  write address
m_axi_lite_awprot_o  out  3  constant 3'b000
m_axi_lite_awvalid_o  out  1  AW valid
m_axi_lite_awready_i  in  1  AW ready
m_axi_lite_wdata_o  out  DataWidth  write data
m_axi_lite_wstrb_o  out  DataWidth/8  constant all ones
m_axi_lite_wvalid_o  out  1  W valid
m_axi_lite_wready_i  in  1  W ready
m_axi_lite_bresp_i  in  2  write response
m_axi_lite_bvalid_i  in  1  B valid
m_axi_lite_bready_o  out  1  B ready

Behaviour:
- Reset values: all valids, bready, busy_o, done_o and error_o = 0; awaddr, wdata, tbl_idx_o, err_idx_o = 0; FSM = IDLE; retry counter = 0.
- Reset is asynchronous. Asserting it mid-transaction drops every valid immediately. No outstanding-transaction recovery is performed.
- FSM states: IDLE, LOAD, ISSUE, RESP, DONE.
- IDLE:
  - start_i=1 with num_entries_i>0: latch num_entries_i, idx=0, clear error_o and err_idx_o, go to LOAD.
  - start_i=1 with num_entries_i=0: go to DONE; no bus traffic.
- LOAD (busy_o=1): capture tbl_addr_i and tbl_data_i at idx into awaddr and wdata, go to ISSUE. Latency: start sampled at edge N, busy_o high from N+1, awvalid and wvalid high from N+2.
- ISSUE:
  - awvalid and wvalid assert together on entry.
  - Each channel drops independently on its own handshake (valid & ready).
  - No valid is withdrawn before its handshake. awaddr and wdata stay stable while either valid is high.
  - Once both channels have handshaked (same or different cycles), go to RESP.
- RESP: bready_o=1. On bvalid:
  - OKAY or EXOKAY: retry=0, idx+1. If idx+1==num go to DONE, else go to LOAD.
  - SLVERR or DECERR with retry<MaxRetries: retry+1, go to ISSUE with the same addr/data.
  - SLVERR or DECERR with retry==MaxRetries: error_o=1, err_idx_o=idx, go to DONE (abort).
- DONE: done_o=1 for exactly one cycle, busy_o=0 next cycle, return to IDLE.
- error_o and err_idx_o hold until the next accepted start.
- start_i is ignored while busy_o=1 or in DONE.
- bready_o is 0 outside RESP. A bvalid outside RESP is never acknowledged.
- Index arithmetic is unsigned IdxWidth. num=2^IdxWidth-1 completes without wrap.
- tbl_idx_o is registered. The table must settle within one cycle (LOAD).

Test Plan:
- 3 entries {0x0:0x11, 0x4:0x22, 0x8:0x33}, AW/W/B ready always 1 → three writes in order, each with awvalid first seen 2 cycles after the preceding start or B handshake; done_o pulses once; error_o=0.
- awready delayed 3 cycles, wready immediate → wvalid drops after 1 cycle; awvalid and awaddr held stable 3 cycles; single B handshake; next entry proceeds.
- Entry 1 returns SLVERR twice then OKAY, MaxRetries=2 → entry 1 written 3 times with identical addr/data; done_o pulses; error_o=0.
- Entry 1 returns DECERR 3 times, MaxRetries=2 → entry 2 never issued; error_o=1, err_idx_o=1, done_o pulses; next start clears error_o.
- num_entries_i=0 with start → done_o one cycle after start; no valids asserted.
- rst_i asserted while awvalid=1 → awvalid, busy_o, error_o fall asynchronously; a post-reset start restarts from idx 0.
